mmio_host_sequencer: RTL
========================

MMIO_HOST_SEQUENCER -- requirements
Module: mmio_host_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 256, number of cycles a request may stay outstanding without ack (legal range 2..65535).
REQ-002 Parameter: INDEX_WIDTH, default 32, MMIO index width, equal to the mmio_if index width.
REQ-003 Parameter: DATA_WIDTH, default 32, MMIO data width, equal to the mmio_if data width.
REQ-004 clock  input  1  single clock; all state changes on rising edge.
REQ-005 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-006 cmd_valid  input  1  command present.
REQ-007 cmd_ready  output  1  sequencer accepts a command this cycle.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_index  input  INDEX_WIDTH  target MMIO index.
REQ-010 cmd_data  input  DATA_WIDTH  write data; ignored for reads.
REQ-011 rsp_valid  output  1  response present.
REQ-012 rsp_ready  input  1  consumer accepts the response.
REQ-013 rsp_data  output  DATA_WIDTH  read data; 0 for writes and errors.
REQ-014 rsp_error  output  1  transaction timed out without ack.
REQ-015 error_count  output  8  saturating count of timed-out transactions.
REQ-016 pe_interface  mmio_if.host  --  drives read_req/read_index/write_req/write_index/write_data; samples read_ack/read_data/write_ack (processing element mapper host side).

Function
REQ-017 FSM states IDLE, READ, WRITE, RESPOND; exactly one state active.
REQ-018 cmd_ready SHALL be 1 only in IDLE; handshake = cmd_valid & cmd_ready at a rising edge.
REQ-019 On handshake with cmd_write=0: latch index, enter READ; with cmd_write=1: latch index and data, enter WRITE.
REQ-020 All MMIO outputs registered; read_req=1 exactly while in READ, write_req=1 exactly while in WRITE; first req cycle is the cycle after handshake.
REQ-021 read_index/write_index/write_data SHALL hold latched values, stable, throughout READ/WRITE; 0 in all other states.
REQ-022 read_req and write_req SHALL never be 1 in the same cycle.
REQ-023 In READ, read_ack=1 sampled at an edge: capture read_data into rsp_data, rsp_error=0, enter RESPOND; req drops the next cycle.
REQ-024 In WRITE, write_ack=1 sampled at an edge: rsp_data=0, rsp_error=0, enter RESPOND.
REQ-025 16-bit timeout counter cleared on entering READ/WRITE, incremented each READ/WRITE cycle without ack.
REQ-026 Req held exactly TIMEOUT_CYCLES cycles without ack: enter RESPOND, rsp_error=1, rsp_data=0, error_count += 1, saturating at 255.
REQ-027 Ack sampled in the same cycle the timeout expires: ack wins, no error.
REQ-028 rsp_valid=1 exactly in RESPOND; rsp_data/rsp_error stable until rsp_valid & rsp_ready.
REQ-029 On response handshake: return to IDLE; cmd_ready=1 next cycle (no command accepted in the RESPOND cycle).
REQ-030 Ack inputs outside READ/WRITE, or the non-matching ack type, SHALL be ignored.
REQ-031 Minimum turnaround with immediate ack and rsp_ready=1: handshake edge -> req 1 cycle -> rsp_valid 1 cycle -> IDLE; 3 cycles per transaction.

Reset
REQ-032 reset_n=0 asynchronously forces IDLE; read_req, write_req, indices, write_data, rsp_valid, rsp_data, rsp_error, error_count = 0; timeout counter = 0.
REQ-033 Reset during READ/WRITE drops req immediately without waiting for the clock; the transaction is discarded with no response.
REQ-034 cmd_ready=1 in the first cycle after reset_n deasserts.

Verification
REQ-035 Read: cmd index 0x10, device acks 2 cycles after req with data 0xDEADBEEF -> read_req high 3 cycles, rsp_valid with rsp_data=0xDEADBEEF, rsp_error=0.
REQ-036 Write: cmd index 0x4, data 0x55 -> write_req/write_index=0x4/write_data=0x55 stable until ack; response rsp_data=0, rsp_error=0.
REQ-037 Timeout: TIMEOUT_CYCLES=8, unmapped index, no ack -> req high exactly 8 cycles, rsp_error=1, error_count=1; 300 timeouts -> error_count=255.
REQ-038 Backpressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held, cmd_ready=0, no new req issued.
REQ-039 Reset mid-READ: reset_n low while read_req=1 -> read_req=0 before the next edge; after release cmd_ready=1, rsp_valid=0.
REQ-040 Race: ack on the final timeout cycle -> rsp_error=0, error_count unchanged; back-to-back commands with immediate ack -> one transaction every 3 cycles.

Source files
------------

// File: rtl/mmio_host_sequencer_if.sv
// Host/device MMIO interface between the sequencer and the processing-element mapper.
interface mmio_if #(
  parameter int INDEX_WIDTH = 32,
  parameter int DATA_WIDTH  = 32
);
  logic                   read_req;
  logic [INDEX_WIDTH-1:0] read_index;
  logic                   read_ack;
  logic [DATA_WIDTH-1:0]  read_data;
  logic                   write_req;
  logic [INDEX_WIDTH-1:0] write_index;
  logic [DATA_WIDTH-1:0]  write_data;
  logic                   write_ack;

  modport host (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_ack, read_data, write_ack
  );

  modport device (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_ack, read_data, write_ack
  );
endinterface

// File: rtl/mmio_host_sequencer.sv
// Single-outstanding MMIO command sequencer: one read or write at a time,
// with per-request timeout and a saturating error counter.
module mmio_host_sequencer #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int INDEX_WIDTH    = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [INDEX_WIDTH-1:0] cmd_index,
  input  logic [DATA_WIDTH-1:0]  cmd_data,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_data,
  output logic                   rsp_error,
  output logic [7:0]             error_count,
  mmio_if.host                   pe_interface
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESPOND} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   read_req_q, read_req_d;
  logic                   write_req_q, write_req_d;
  logic [INDEX_WIDTH-1:0] read_index_q, read_index_d;
  logic [INDEX_WIDTH-1:0] write_index_q, write_index_d;
  logic [DATA_WIDTH-1:0]  write_data_q, write_data_d;
  logic [DATA_WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic                   rsp_error_q, rsp_error_d;
  logic [7:0]             err_cnt_q, err_cnt_d;
  logic [15:0]            tmo_q, tmo_d;

  always_comb begin
    state_d       = state_q;
    read_req_d    = read_req_q;
    write_req_d   = write_req_q;
    read_index_d  = read_index_q;
    write_index_d = write_index_q;
    write_data_d  = write_data_q;
    rsp_data_d    = rsp_data_q;
    rsp_error_d   = rsp_error_q;
    err_cnt_d     = err_cnt_q;
    tmo_d         = tmo_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tmo_d = '0;
          if (cmd_write) begin
            state_d       = WRITE;
            write_req_d   = 1'b1;
            write_index_d = cmd_index;
            write_data_d  = cmd_data;
          end else begin
            state_d      = READ;
            read_req_d   = 1'b1;
            read_index_d = cmd_index;
          end
        end
      end
      READ, WRITE: begin
        // An ack arriving on the last allowed cycle still completes cleanly.
        if ((state_q == READ) ? pe_interface.read_ack : pe_interface.write_ack) begin
          state_d     = RESPOND;
          rsp_data_d  = (state_q == READ) ? pe_interface.read_data : '0;
          rsp_error_d = 1'b0;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = RESPOND;
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
        if (state_d == RESPOND) begin
          read_req_d    = 1'b0;
          write_req_d   = 1'b0;
          read_index_d  = '0;
          write_index_d = '0;
          write_data_d  = '0;
        end
      end
      RESPOND: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      read_req_q    <= 1'b0;
      write_req_q   <= 1'b0;
      read_index_q  <= '0;
      write_index_q <= '0;
      write_data_q  <= '0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      err_cnt_q     <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      read_req_q    <= read_req_d;
      write_req_q   <= write_req_d;
      read_index_q  <= read_index_d;
      write_index_q <= write_index_d;
      write_data_q  <= write_data_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      err_cnt_q     <= err_cnt_d;
      tmo_q         <= tmo_d;
    end
  end

  assign cmd_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESPOND);
  assign rsp_data    = rsp_data_q;
  assign rsp_error   = rsp_error_q;
  assign error_count = err_cnt_q;

  assign pe_interface.read_req    = read_req_q;
  assign pe_interface.read_index  = read_index_q;
  assign pe_interface.write_req   = write_req_q;
  assign pe_interface.write_index = write_index_q;
  assign pe_interface.write_data  = write_data_q;

endmodule
